// File: rtl/scan_pkg.sv
// Shared definitions for the scanner link arbiter.
// Holds the command byte codes seen on the scanner serial frames, the control
// codes driven back to the scanners, and the link FSM state encoding.
package scan_pkg;

  localparam logic [7:0] CMD_NEAR  = 8'd2;
  localparam logic [7:0] CMD_START = 8'd3;
  localparam logic [7:0] CMD_FULL  = 8'd4;
  localparam logic [7:0] CMD_DATA  = 8'd7;

  localparam logic [1:0] CTRL_NONE    = 2'b00;
  localparam logic [1:0] CTRL_START   = 2'b01;
  localparam logic [1:0] CTRL_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    LINK_IDLE    = 2'd0,
    LINK_GRANT   = 2'd1,
    LINK_RELEASE = 2'd2
  } link_state_e;

endpackage

// File: rtl/scan_frame_rx.sv
// Serial frame deserializer for one scanner channel.
// Eight bit strobes (MSB first) form one byte; frame_valid_o pulses for one
// cycle after the eighth strobe. The byte following a CMD_DATA header is
// flagged as data; every other byte is a command.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bit_valid_i       one serial bit present on bit_data_i
//   bit_data_i        serial bit
//   frame_valid_o     one-cycle pulse, frame_byte_o/frame_is_data_o valid
//   frame_byte_o      assembled byte
//   frame_is_data_o   byte is a data payload rather than a command
module scan_frame_rx
  import scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid_i,
  input  logic       bit_data_i,
  output logic       frame_valid_o,
  output logic [7:0] frame_byte_o,
  output logic       frame_is_data_o
);

  logic [6:0] shift_q;
  logic [2:0] cnt_q;
  logic       data_next_q;
  logic       frame_valid_q;
  logic [7:0] frame_byte_q;
  logic       frame_is_data_q;
  logic [7:0] byte_w;

  assign byte_w = {shift_q, bit_data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q         <= '0;
      cnt_q           <= '0;
      data_next_q     <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_byte_q    <= '0;
      frame_is_data_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      if (bit_valid_i) begin
        shift_q <= byte_w[6:0];
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          frame_valid_q   <= 1'b1;
          frame_byte_q    <= byte_w;
          frame_is_data_q <= data_next_q;
          // A payload byte equal to CMD_DATA is data, not a fresh header.
          data_next_q     <= !data_next_q && (byte_w == CMD_DATA);
        end
      end
    end
  end

  assign frame_valid_o   = frame_valid_q;
  assign frame_byte_o    = frame_byte_q;
  assign frame_is_data_o = frame_is_data_q;

endmodule

// File: rtl/scan_link_arbiter.sv
// Controller for two scanners sharing one transfer link.
// Decodes scanner frames, issues START/RELEASE control codes (each held for
// CMD_HOLD cycles), and grants the link round-robin to one full scanner at a
// time, forwarding its data byte downstream.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   go             pulse: request START on channel 0
//   bit_valid/data per-channel serial input
//   ctrl0, ctrl1   control codes to scanners
//   rdy_xfer       one-hot link grant
//   near_full      per-channel near-full flag
//   xfer_valid/src/data  forwarded data byte
//   busy           grant active
//   err_timeout    pulse on forced release
//
// Link FSM states:
//   state        | meaning
//   LINK_IDLE    | no grant; pick a pending channel (RR on tie)
//   LINK_GRANT   | link granted to gnt_q, timeout running
//   LINK_RELEASE | drop grant, clear flags, request RELEASE ctrl
module scan_link_arbiter
  import scan_pkg::*;
#(
  parameter int CMD_HOLD = 8,
  parameter int TIMEOUT  = 1024,
  parameter int CW       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] bit_valid,
  input  logic [1:0] bit_data,
  output logic [1:0] ctrl0,
  output logic [1:0] ctrl1,
  output logic [1:0] rdy_xfer,
  output logic [1:0] near_full,
  output logic       xfer_valid,
  output logic       xfer_src,
  output logic [7:0] xfer_data,
  output logic       busy,
  output logic       err_timeout
);

  localparam int HW = $clog2(CMD_HOLD + 1);

  logic [1:0]      fv;
  logic [1:0][7:0] fb;
  logic [1:0]      fd;

  for (genvar g = 0; g < 2; g++) begin : g_rx
    scan_frame_rx u_rx (
      .clk             (clk),
      .rst             (rst),
      .bit_valid_i     (bit_valid[g]),
      .bit_data_i      (bit_data[g]),
      .frame_valid_o   (fv[g]),
      .frame_byte_o    (fb[g]),
      .frame_is_data_o (fd[g])
    );
  end

  link_state_e     state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            rr_q, rr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [1:0]      pending_q, pending_d;
  logic [1:0]      near_q, near_d;
  logic            xv_q, xv_d;
  logic            xs_q, xs_d;
  logic [7:0]      xd_q, xd_d;
  logic            err_q, err_d;

  logic [1:0]         active_q, active_d;
  logic [1:0]         st_wait_q, st_wait_d;
  logic [1:0]         rel_wait_q, rel_wait_d;
  logic [1:0][HW-1:0] hold_q, hold_d;
  logic [1:0][1:0]    code_q, code_d;

  logic [1:0] cmd_near, cmd_start, cmd_full;
  logic [1:0] start_req, rel_req, flag_clr, full_block;

  always_comb begin
    cmd_near  = '0;
    cmd_start = '0;
    cmd_full  = '0;
    for (int i = 0; i < 2; i++) begin
      cmd_near[i]  = fv[i] && !fd[i] && (fb[i] == CMD_NEAR);
      cmd_start[i] = fv[i] && !fd[i] && (fb[i] == CMD_START);
      cmd_full[i]  = fv[i] && !fd[i] && (fb[i] == CMD_FULL);
    end
    // A START from one scanner targets the other one.
    start_req[0] = (go | cmd_start[1]) & ~active_q[0] & ~st_wait_q[0];
    start_req[1] = cmd_start[0] & ~active_q[1] & ~st_wait_q[1];
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    tmo_d    = tmo_q;
    xv_d     = 1'b0;
    xs_d     = xs_q;
    xd_d     = xd_q;
    err_d    = 1'b0;
    rel_req  = 2'b00;
    flag_clr = 2'b00;
    unique case (state_q)
      LINK_IDLE: begin
        if (|pending_q) begin
          // rr_q holds the last granted channel.
          gnt_d   = (&pending_q) ? ~rr_q : pending_q[1];
          tmo_d   = CW'(TIMEOUT);
          state_d = LINK_GRANT;
        end
      end
      LINK_GRANT: begin
        if (fv[gnt_q] && fd[gnt_q]) begin
          xv_d    = 1'b1;
          xs_d    = gnt_q;
          xd_d    = fb[gnt_q];
          state_d = LINK_RELEASE;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = LINK_RELEASE;
        end else begin
          tmo_d = tmo_q - CW'(1);
        end
      end
      LINK_RELEASE: begin
        rel_req[gnt_q]  = 1'b1;
        flag_clr[gnt_q] = 1'b1;
        rr_d            = gnt_q;
        state_d         = LINK_IDLE;
      end
      default: state_d = LINK_IDLE;
    endcase
  end

  assign full_block = (state_q == LINK_GRANT) ? (2'b01 << gnt_q) : 2'b00;
  assign pending_d  = (pending_q & ~flag_clr) | (cmd_full & ~full_block);
  assign near_d     = (near_q & ~flag_clr) | cmd_near;

  // Control issue: one code per channel at a time, RELEASE before START.
  always_comb begin
    active_d   = active_q;
    st_wait_d  = st_wait_q | start_req;
    rel_wait_d = rel_wait_q | rel_req;
    hold_d     = hold_q;
    code_d     = code_q;
    for (int i = 0; i < 2; i++) begin
      if (hold_q[i] != '0) begin
        hold_d[i] = hold_q[i] - HW'(1);
      end else if (rel_wait_d[i]) begin
        code_d[i]     = CTRL_RELEASE;
        hold_d[i]     = HW'(CMD_HOLD);
        rel_wait_d[i] = 1'b0;
        active_d[i]   = 1'b0;
      end else if (st_wait_d[i]) begin
        code_d[i]    = CTRL_START;
        hold_d[i]    = HW'(CMD_HOLD);
        st_wait_d[i] = 1'b0;
        active_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LINK_IDLE;
      gnt_q      <= 1'b0;
      rr_q       <= 1'b0;
      tmo_q      <= '0;
      pending_q  <= '0;
      near_q     <= '0;
      xv_q       <= 1'b0;
      xs_q       <= 1'b0;
      xd_q       <= '0;
      err_q      <= 1'b0;
      active_q   <= '0;
      st_wait_q  <= '0;
      rel_wait_q <= '0;
      hold_q     <= '0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      tmo_q      <= tmo_d;
      pending_q  <= pending_d;
      near_q     <= near_d;
      xv_q       <= xv_d;
      xs_q       <= xs_d;
      xd_q       <= xd_d;
      err_q      <= err_d;
      active_q   <= active_d;
      st_wait_q  <= st_wait_d;
      rel_wait_q <= rel_wait_d;
      hold_q     <= hold_d;
      code_q     <= code_d;
    end
  end

  assign ctrl0       = (hold_q[0] != '0) ? code_q[0] : CTRL_NONE;
  assign ctrl1       = (hold_q[1] != '0) ? code_q[1] : CTRL_NONE;
  assign rdy_xfer    = (state_q == LINK_GRANT) ? (2'b01 << gnt_q) : 2'b00;
  assign busy        = (state_q == LINK_GRANT);
  assign near_full   = near_q;
  assign xfer_valid  = xv_q;
  assign xfer_src    = xs_q;
  assign xfer_data   = xd_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_scan_link_arbiter.sv
module tb_scan_link_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [1:0] bit_valid = 2'b00;
  logic [1:0] bit_data = 2'b00;
  logic [1:0] ctrl0, ctrl1, rdy_xfer, near_full;
  logic       xfer_valid, xfer_src, busy, err_timeout;
  logic [7:0] xfer_data;

  int tests = 0;
  int fails = 0;

  scan_link_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .ctrl0       (ctrl0),
    .ctrl1       (ctrl1),
    .rdy_xfer    (rdy_xfer),
    .near_full   (near_full),
    .xfer_valid  (xfer_valid),
    .xfer_src    (xfer_src),
    .xfer_data   (xfer_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go = 1'b0;
    bit_valid = 2'b00;
    bit_data = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives 8 strobes, MSB first, on the channels enabled in en.
  task automatic send(input logic [1:0] en, input logic [7:0] b0, input logic [7:0] b1);
    for (int k = 7; k >= 0; k--) begin
      bit_valid = en;
      bit_data  = {b1[k], b0[k]};
      tick();
    end
    bit_valid = 2'b00;
    bit_data  = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({ctrl0, ctrl1, rdy_xfer, near_full} !== 8'h00) begin
      $display("FAIL reset_ctrl: got %h required 00", {ctrl0, ctrl1, rdy_xfer, near_full});
      fails++;
    end
    tests++;
    if ({xfer_valid, xfer_src, xfer_data, busy, err_timeout} !== 12'h000) begin
      $display("FAIL reset_xfer: got %h required 000",
               {xfer_valid, xfer_src, xfer_data, busy, err_timeout});
      fails++;
    end
  endtask

  task automatic test_start();
    int n;
    do_reset();
    go = 1'b1;
    tick();
    go = 1'b0;
    n = 0;
    while (ctrl0 === 2'b01 && n < 20) begin
      n++;
      tick();
    end
    tests++;
    if (n !== 8) begin
      $display("FAIL go_start_hold: got %0d cycles required 8", n);
      fails++;
    end
    // ch0 is active now; a second go must be ignored.
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tests++;
    if (ctrl0 !== 2'b00) begin
      $display("FAIL go_ignored_active: got %b required 00", ctrl0);
      fails++;
    end
    send(2'b01, 8'h03, 8'h00);
    tests++;
    if (ctrl1 !== 2'b00) begin
      $display("FAIL start_ch1_early: got %b required 00", ctrl1);
      fails++;
    end
    tick();
    n = 0;
    while (ctrl1 === 2'b01 && n < 20) begin
      n++;
      tick();
    end
    tests++;
    if (n !== 8) begin
      $display("FAIL start_ch1_hold: got %0d cycles required 8", n);
      fails++;
    end
  endtask

  task automatic test_single_xfer();
    int n;
    do_reset();
    send(2'b01, 8'h02, 8'h00);
    tick();
    tests++;
    if (near_full !== 2'b01) begin
      $display("FAIL near_full_set: got %b required 01", near_full);
      fails++;
    end
    send(2'b01, 8'h04, 8'h00);
    tick();
    tests++;
    if (rdy_xfer !== 2'b00) begin
      $display("FAIL grant_early: got %b required 00", rdy_xfer);
      fails++;
    end
    tick();
    tests++;
    if (rdy_xfer !== 2'b01 || busy !== 1'b1) begin
      $display("FAIL grant_ch0: got rdy %b busy %b required 01 1", rdy_xfer, busy);
      fails++;
    end
    // FULL from the granted channel must not re-arm a grant.
    send(2'b01, 8'h04, 8'h00);
    send(2'b01, 8'h07, 8'h00);
    send(2'b01, 8'hA5, 8'h00);
    tests++;
    if (xfer_valid !== 1'b0) begin
      $display("FAIL xfer_early: got %b required 0", xfer_valid);
      fails++;
    end
    tick();
    tests++;
    if ({xfer_valid, xfer_src, xfer_data, rdy_xfer, busy} !== {1'b1, 1'b0, 8'hA5, 2'b00, 1'b0}) begin
      $display("FAIL xfer_ch0: got v%b s%b d%h rdy%b busy%b required v1 s0 dA5 rdy00 busy0",
               xfer_valid, xfer_src, xfer_data, rdy_xfer, busy);
      fails++;
    end
    tick();
    tests++;
    if ({ctrl0, near_full, xfer_valid} !== {2'b10, 2'b00, 1'b0}) begin
      $display("FAIL release_ch0: got ctrl0 %b near %b v %b required 10 00 0",
               ctrl0, near_full, xfer_valid);
      fails++;
    end
    n = 0;
    while (ctrl0 === 2'b10 && n < 20) begin
      n++;
      tick();
    end
    tests++;
    if (n !== 8) begin
      $display("FAIL release_hold: got %0d cycles required 8", n);
      fails++;
    end
    tests++;
    if (rdy_xfer !== 2'b00) begin
      $display("FAIL full_ignored_granted: got %b required 00", rdy_xfer);
      fails++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    send(2'b11, 8'h04, 8'h04);
    tick();
    tick();
    tests++;
    if (rdy_xfer !== 2'b10) begin
      $display("FAIL rr_first_ch1: got %b required 10", rdy_xfer);
      fails++;
    end
    send(2'b10, 8'h00, 8'h07);
    send(2'b10, 8'h00, 8'h5A);
    tick();
    tests++;
    if ({xfer_valid, xfer_src, xfer_data} !== {1'b1, 1'b1, 8'h5A}) begin
      $display("FAIL xfer_ch1: got v%b s%b d%h required v1 s1 d5A", xfer_valid, xfer_src, xfer_data);
      fails++;
    end
    tick();
    tests++;
    if (rdy_xfer !== 2'b00) begin
      $display("FAIL rr_gap: got %b required 00", rdy_xfer);
      fails++;
    end
    tick();
    tests++;
    if (rdy_xfer !== 2'b01) begin
      $display("FAIL rr_second_ch0: got %b required 01", rdy_xfer);
      fails++;
    end
    // ch1 data while ch0 holds the link is dropped.
    send(2'b10, 8'h00, 8'h07);
    send(2'b10, 8'h00, 8'h33);
    tick();
    tests++;
    if (xfer_valid !== 1'b0 || rdy_xfer !== 2'b01) begin
      $display("FAIL drop_nongranted: got v%b rdy%b required v0 rdy01", xfer_valid, rdy_xfer);
      fails++;
    end
    send(2'b01, 8'h07, 8'h00);
    send(2'b01, 8'h11, 8'h00);
    tick();
    tests++;
    if ({xfer_valid, xfer_src, xfer_data} !== {1'b1, 1'b0, 8'h11}) begin
      $display("FAIL xfer_ch0_after_rr: got v%b s%b d%h required v1 s0 d11",
               xfer_valid, xfer_src, xfer_data);
      fails++;
    end
  endtask

  task automatic test_timeout();
    int   n;
    logic last_busy;
    do_reset();
    send(2'b10, 8'h00, 8'h04);
    tick();
    tick();
    tests++;
    if (rdy_xfer !== 2'b10) begin
      $display("FAIL tmo_grant_ch1: got %b required 10", rdy_xfer);
      fails++;
    end
    n = 0;
    last_busy = busy;
    while (err_timeout !== 1'b1 && n < 2000) begin
      last_busy = busy;
      n++;
      tick();
    end
    tests++;
    if (n !== 1025) begin
      $display("FAIL tmo_cycles: got %0d required 1025", n);
      fails++;
    end
    tests++;
    if (last_busy !== 1'b1 || busy !== 1'b0 || rdy_xfer !== 2'b00) begin
      $display("FAIL tmo_release: got last_busy %b busy %b rdy %b required 1 0 00",
               last_busy, busy, rdy_xfer);
      fails++;
    end
    tick();
    tests++;
    if (ctrl1 !== 2'b10 || err_timeout !== 1'b0) begin
      $display("FAIL tmo_ctrl1: got ctrl1 %b err %b required 10 0", ctrl1, err_timeout);
      fails++;
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send(2'b10, 8'h00, 8'h02);
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bit_valid = 2'b01;
      bit_data  = 2'b01;
      tick();
    end
    tests++;
    if (ctrl0 !== 2'b01 || near_full !== 2'b10) begin
      $display("FAIL pre_reset_state: got ctrl0 %b near %b required 01 10", ctrl0, near_full);
      fails++;
    end
    rst = 1'b1;
    bit_valid = 2'b00;
    bit_data  = 2'b00;
    tick();
    tests++;
    if ({ctrl0, ctrl1, rdy_xfer, near_full, xfer_valid, busy, err_timeout} !== 11'h000) begin
      $display("FAIL midframe_reset: got %h required 000",
               {ctrl0, ctrl1, rdy_xfer, near_full, xfer_valid, busy, err_timeout});
      fails++;
    end
    rst = 1'b0;
    send(2'b01, 8'h02, 8'h00);
    tick();
    tests++;
    if (near_full !== 2'b01) begin
      $display("FAIL post_reset_frame: got %b required 01", near_full);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_single_xfer();
    test_round_robin();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
